// File: rtl/fmap_stream_src_if.sv
// rtl/fmap_stream_src_if.sv - buffer read port, convolution stream and control bundle for fmap_stream_src
interface fmap_stream_src_if #(
   parameter int I_BW    = 8,
   parameter int ADDR_BW = 10
);
   logic               i_start;
   logic               i_stall;
   logic               o_rd_en;
   logic [ADDR_BW-1:0] o_rd_addr;
   logic [I_BW-1:0]    i_rd_data;
   logic [I_BW-1:0]    o_fmap;
   logic               o_ce;
   logic               i_conv_end;
   logic               o_self_rst;
   logic               o_busy;
   logic               o_done;
   logic               o_err;

   modport master (
      input  i_start, i_stall, i_rd_data, i_conv_end,
      output o_rd_en, o_rd_addr, o_fmap, o_ce, o_self_rst, o_busy, o_done, o_err
   );

   modport slave (
      output i_start, i_stall, i_rd_data, i_conv_end,
      input  o_rd_en, o_rd_addr, o_fmap, o_ce, o_self_rst, o_busy, o_done, o_err
   );
endinterface

// File: rtl/fmap_stream_src.sv
// rtl/fmap_stream_src.sv - raster feature-map source, re-streamed once per output channel
// Optional flush watchdog compiled in with FMAP_SRC_WATCHDOG_EN.
module fmap_stream_src #(
   parameter int I_BW    = 8,
   parameter int I_SIZE  = 28,
   parameter int CO      = 4,
   parameter int ADDR_BW = 10,
   parameter int WD_CYC  = 64
) (
   input  logic              clk,
   input  logic              rst,
   fmap_stream_src_if.master bus
);
   localparam int N     = I_SIZE * I_SIZE;
   localparam int CH_BW = $clog2(CO) + 1;
   localparam logic [ADDR_BW-1:0] LAST_ADDR = ADDR_BW'(N - 1);
   localparam logic [CH_BW-1:0]   LAST_CH   = CH_BW'(CO - 1);

   if ((2 ** ADDR_BW) < N) begin : g_addr_chk
      $error("ADDR_BW too narrow for I_SIZE*I_SIZE");
   end
   if (WD_CYC < 1 || CO < 1) begin : g_cfg_chk
      $error("WD_CYC and CO must be at least 1");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_STREAM,
      S_FLUSH,
      S_CHRST,
      S_DONE
   } state_t;

   state_t             state;
   state_t             state_nx;
   logic [ADDR_BW-1:0] addr_q;
   logic [ADDR_BW-1:0] addr_nx;
   logic [CH_BW-1:0]   ch_q;
   logic [CH_BW-1:0]   ch_nx;
   logic               ce_pipe;
   logic               rd_en;
   logic               flush_ce;
   logic               self_rst;
   logic               done;
   logic               wd_hit;

   always_comb begin
      state_nx = state;
      addr_nx  = addr_q;
      ch_nx    = ch_q;
      rd_en    = 1'b0;
      flush_ce = 1'b0;
      self_rst = 1'b0;
      done     = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.i_start) begin
               state_nx = S_STREAM;
               addr_nx  = '0;
               ch_nx    = '0;
            end
         end
         S_STREAM: begin
            rd_en = ~bus.i_stall;
            if (rd_en) begin
               // Hold the counter on the last read so it never wraps inside a pass
               if (addr_q == LAST_ADDR) begin
                  state_nx = S_FLUSH;
               end else begin
                  addr_nx = addr_q + 1'b1;
               end
            end
         end
         S_FLUSH: begin
            // The first FLUSH cycle carries the last in-flight pixel, not a flush strobe
            flush_ce = ~ce_pipe & ~bus.i_stall & ~bus.i_conv_end;
            if (bus.i_conv_end || wd_hit) begin
               state_nx = S_CHRST;
            end
         end
         S_CHRST: begin
            self_rst = 1'b1;
            ch_nx    = ch_q + 1'b1;
            if (ch_q == LAST_CH) begin
               state_nx = S_DONE;
            end else begin
               addr_nx  = '0;
               state_nx = S_STREAM;
            end
         end
         S_DONE: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         addr_q  <= '0;
         ch_q    <= '0;
         ce_pipe <= 1'b0;
      end else begin
         state   <= state_nx;
         addr_q  <= addr_nx;
         ch_q    <= ch_nx;
         ce_pipe <= rd_en;
      end
   end

`ifdef FMAP_SRC_WATCHDOG_EN
   localparam int WD_BW = $clog2(WD_CYC + 1);

   logic [WD_BW-1:0] wd_q;
   logic             err_q;

   assign wd_hit = flush_ce && (wd_q == WD_BW'(WD_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         if (state != S_FLUSH) begin
            wd_q <= '0;
         end else if (flush_ce) begin
            wd_q <= wd_q + 1'b1;
         end
         err_q <= err_q | wd_hit;
      end
   end

   assign bus.o_err = err_q;
`else
   assign wd_hit    = 1'b0;
   assign bus.o_err = 1'b0;
`endif

   assign bus.o_rd_en    = rd_en;
   assign bus.o_rd_addr  = (state == S_STREAM) ? addr_q : '0;
   assign bus.o_ce       = ce_pipe | flush_ce;
   assign bus.o_fmap     = ce_pipe ? bus.i_rd_data : '0;
   assign bus.o_self_rst = self_rst;
   assign bus.o_busy     = (state != S_IDLE);
   assign bus.o_done     = done;
endmodule

// File: tb/tb_fmap_stream_src.sv
// tb/tb_fmap_stream_src.sv - table-driven bench for fmap_stream_src (I_SIZE=4, CO=2)
module tb_fmap_stream_src;
   localparam int I_BW    = 8;
   localparam int I_SIZE  = 4;
   localparam int CO      = 2;
   localparam int ADDR_BW = 4;
   localparam int WD_CYC  = 8;
   localparam int N       = I_SIZE * I_SIZE;

   typedef struct {
      logic               start;
      logic               stall;
      logic               conv_end;
      logic               rd_en;
      logic [ADDR_BW-1:0] addr;
      logic               ce;
      logic [I_BW-1:0]    fmap;
      logic               self_rst;
      logic               busy;
      logic               done;
      logic               err;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic [I_BW-1:0] mem [0:N-1];
   vec_t tbl[$];
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fmap_stream_src_if #(.I_BW(I_BW), .ADDR_BW(ADDR_BW)) bus ();

   fmap_stream_src #(
      .I_BW(I_BW), .I_SIZE(I_SIZE), .CO(CO), .ADDR_BW(ADDR_BW), .WD_CYC(WD_CYC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Single-port buffer with one cycle of read latency
   always @(posedge clk) begin
      if (bus.o_rd_en) bus.i_rd_data <= mem[bus.o_rd_addr];
   end

   task automatic add_row(input bit st, input bit sl, input bit cv, input bit rd, input int a,
                          input bit ce, input int f, input bit sr, input bit b, input bit d,
                          input bit e);
      vec_t v;
      v.start = st; v.stall = sl; v.conv_end = cv;
      v.rd_en = rd; v.addr = ADDR_BW'(a); v.ce = ce; v.fmap = I_BW'(f);
      v.self_rst = sr; v.busy = b; v.done = d; v.err = e;
      tbl.push_back(v);
   endtask

   // Expected cycle-by-cycle trace of a full CO-pass run, derived from the timing rules
   task automatic build_run(input int stall_pass, input int stall_at, input int stall_len,
                            input bit noise, input int nflush, input bit wd);
      int addr, scount, prev_a;
      bit prev_rd, sl, rd, e;
      tbl.delete();
      e = 1'b0;
      add_row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, e);
      for (int p = 0; p < CO; p++) begin
         addr = 0; prev_rd = 1'b0; prev_a = 0; scount = 0;
         while (addr < N) begin
            sl = (p == stall_pass) && (addr == stall_at) && (scount < stall_len);
            if (sl) scount++;
            rd = !sl;
            add_row(noise && addr == 3, sl, noise && addr == 7, rd, addr,
                    prev_rd, prev_rd ? prev_a + 1 : 0, 0, 1, 0, e);
            prev_rd = rd; prev_a = addr;
            if (rd) addr++;
         end
         add_row(0, 0, 0, 0, 0, 1, prev_a + 1, 0, 1, 0, e);
         for (int k = 0; k < nflush; k++) add_row(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, e);
         if (wd) e = 1'b1;
         else    add_row(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, e);
         add_row(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, e);
      end
      add_row(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, e);
      add_row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e);
   endtask

   task automatic check_vec(input string name, input int idx, input vec_t v);
      total++;
      if (bus.o_rd_en !== v.rd_en || bus.o_rd_addr !== v.addr || bus.o_ce !== v.ce ||
          bus.o_fmap !== v.fmap || bus.o_self_rst !== v.self_rst || bus.o_busy !== v.busy ||
          bus.o_done !== v.done || bus.o_err !== v.err) begin
         bad++;
         $display("FAIL %s row %0d: got rd_en=%b addr=%0d ce=%b fmap=%0d srst=%b busy=%b done=%b err=%b, want rd_en=%b addr=%0d ce=%b fmap=%0d srst=%b busy=%b done=%b err=%b",
                  name, idx, bus.o_rd_en, bus.o_rd_addr, bus.o_ce, bus.o_fmap, bus.o_self_rst,
                  bus.o_busy, bus.o_done, bus.o_err, v.rd_en, v.addr, v.ce, v.fmap,
                  v.self_rst, v.busy, v.done, v.err);
      end
   endtask

   task automatic run_rows(input string name, input int last);
      for (int i = 0; i <= last; i++) begin
         @(negedge clk);
         bus.i_start    = tbl[i].start;
         bus.i_stall    = tbl[i].stall;
         bus.i_conv_end = tbl[i].conv_end;
         #1;
         check_vec(name, i, tbl[i]);
      end
   endtask

   task automatic idle_inputs();
      bus.i_start = 1'b0; bus.i_stall = 1'b0; bus.i_conv_end = 1'b0;
   endtask

   initial begin
      vec_t z;
      int hits, stop;
      z = '{default: 1'b0};
      for (int i = 0; i < N; i++) mem[i] = I_BW'(i + 1);
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      #1;
      check_vec("reset_state", 0, z);
      rst = 1'b0;

      build_run(-1, 0, 0, 1'b0, 3, 1'b0);
      run_rows("basic", tbl.size() - 1);

      build_run(0, 5, 3, 1'b0, 3, 1'b0);
      run_rows("stall", tbl.size() - 1);

      build_run(-1, 0, 0, 1'b1, 3, 1'b0);
      run_rows("ignored_inputs", tbl.size() - 1);

      // Abort in pass 2 on the cycle pixel 9 is presented
      build_run(-1, 0, 0, 1'b0, 3, 1'b0);
      hits = 0; stop = 0;
      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].ce && tbl[i].fmap == 8'd9) begin
            hits++;
            if (hits == 2) stop = i;
         end
      end
      run_rows("pre_abort", stop);
      #1 rst = 1'b1;
      #1 check_vec("abort_outputs_zero", 0, z);
      idle_inputs();
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1 check_vec("post_abort_idle", c, z);
      end
      build_run(-1, 0, 0, 1'b0, 3, 1'b0);
      run_rows("replay", tbl.size() - 1);

`ifdef FMAP_SRC_WATCHDOG_EN
      build_run(-1, 0, 0, 1'b0, WD_CYC, 1'b1);
      run_rows("watchdog", tbl.size() - 1);
      @(negedge clk);
      rst = 1'b1;
      #1 check_vec("watchdog_rst_clear", 0, z);
      @(negedge clk);
      rst = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fmap_stream_src.md
# fmap_stream_src

Raster-order feature-map source that feeds the streaming 5x5 convolution layers. It reads an I_SIZE x I_SIZE input map from a synchronous single-port buffer (1-cycle read latency) and presents one pixel per enabled cycle on o_fmap/o_ce. After each map it drives zero-valued flush cycles until the convolution reports end-of-map, pulses o_self_rst to advance the convolution's output-channel counter, and re-streams the same map once per output channel, CO times in total.

## Interface
- I_BW, 8, pixel width
- I_SIZE, 28, map edge length; I_SIZE*I_SIZE pixels per pass
- CO, 4, number of passes (output channels)
- ADDR_BW, 10, buffer address width; must satisfy 2^ADDR_BW >= I_SIZE*I_SIZE
- WD_CYC, 64, watchdog limit in flush cycles (used only with FMAP_SRC_WATCHDOG_EN)

- clk  in  1  single clock; all logic is rising-edge
- rst  in  1  asynchronous, active-high reset
- i_start  in  1  one-cycle start request; honoured only in IDLE
- i_stall  in  1  backpressure; while high, no new reads are issued and no flush ce is driven
- o_rd_en  out  1  buffer read enable
- o_rd_addr  out  ADDR_BW  buffer read address
- i_rd_data  in  I_BW  buffer data, valid the cycle after o_rd_en
- o_fmap  out  I_BW  pixel to the convolution; zero during flush
- o_ce  out  1  pixel/flush strobe to the convolution
- i_conv_end  in  1  end-of-map indication from the convolution
- o_self_rst  out  1  one-cycle pulse between passes
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse after the final pass
- o_err  out  1  sticky watchdog flag; constant 0 when the watchdog is compiled out

## Operation
- States: IDLE, STREAM, FLUSH, CHRST, DONE.
- IDLE -> STREAM on i_start. Address counter and channel counter are cleared to 0.
- STREAM:
  - o_rd_en = ~i_stall, o_rd_addr = address counter.
  - The address counter increments on each issued read.
  - After the read of address I_SIZE*I_SIZE-1 is issued, go to FLUSH.
- Read pipeline:
  - A 1-bit delayed copy of o_rd_en becomes o_ce.
  - o_fmap = i_rd_data registered in that same cycle.
  - Reads already in flight are always delivered, even if i_stall rises.
- FLUSH:
  - In the first FLUSH cycle, the last pixel from the read pipeline is emitted.
  - Afterwards, o_ce = ~i_stall and o_fmap = 0.
  - On i_conv_end sampled high, go to CHRST. The flush ce in that same cycle is suppressed.
- CHRST:
  - o_self_rst = 1 and o_ce = 0 for exactly one cycle; the channel counter increments.
  - If the channel counter was CO-1, go to DONE. Otherwise clear the address counter and go to STREAM.
- DONE: o_done = 1 for one cycle, then go to IDLE.
- i_start outside IDLE is ignored. i_conv_end outside FLUSH is ignored.
- Reset, in any state including mid-pass:
  - Forces IDLE and clears all counters and the pipeline.
  - Every output goes to 0: o_rd_en, o_rd_addr, o_fmap, o_ce, o_self_rst, o_busy, o_done, o_err.
  - No o_self_rst or o_done pulse is generated by an abort.

## Timing
- i_start sampled at cycle T: o_rd_en=1 with address 0 at T+1; first o_ce with pixel 0 at T+2.
- Without stall, pixels 0..N-1 (N=I_SIZE*I_SIZE) appear on N consecutive cycles, T+2..T+N+1.
- Flush ce begins at T+N+2.
- Stall of k cycles delays all subsequent reads and strobes by exactly k cycles. Pixel order and values are unchanged.
- i_conv_end sampled high at cycle E: o_self_rst at E+1; the next pass has o_rd_en at E+2 and its first o_ce at E+3.
- Final pass: o_done at E+2; o_busy falls at E+3.
- The channel counter is clog2(CO)+1 bits wide. The address counter is ADDR_BW bits wide and never wraps within a pass.

## Configuration
- FMAP_SRC_WATCHDOG_EN defined:
  - A flush counter runs in FLUSH, counting cycles with o_ce=1.
  - If it reaches WD_CYC before i_conv_end is seen, o_err is set (sticky until rst) and the FSM proceeds to CHRST as if i_conv_end had arrived.
- Not defined: no counter; FLUSH waits indefinitely; o_err is tied to 0.

## Test plan
Bench parameters: I_SIZE=4, CO=2, buffer holds values 1..16.
- Basic: i_start, model asserts i_conv_end on the 3rd flush ce -> o_ce carries 1..16 on 16 consecutive cycles, then 3 zero flush ce, then one o_self_rst; repeated for the second pass; then o_done, o_busy low. Total 2 o_self_rst pulses.
- Stall: i_stall high for 3 cycles after pixel 5 -> pixels 6..16 each shifted exactly 3 cycles later; no duplicates or drops.
- i_start pulsed mid-pass and i_conv_end pulsed during STREAM -> both ignored; stream identical to the basic case.
- rst asserted during pass 2 at pixel 9 -> all outputs 0 the same cycle; no o_done. A fresh i_start replays from pass 1, pixel 1.
- FMAP_SRC_WATCHDOG_EN with WD_CYC=8, i_conv_end never asserted -> 8 flush ce, then o_err=1 and o_self_rst; o_err stays 1 through o_done until rst.
